// File: rtl/l15_anycore_pkg.sv
// Shared types, request-type/size codes and data helpers for the anycore <-> L1.5 decoders.
// Used by both the request-side and response-side blocks.
package l15_anycore_pkg;

    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        SRC_IFILL = 2'd0,
        SRC_LOAD  = 2'd1,
        SRC_STORE = 2'd2
    } src_e;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_e;

    localparam logic [4:0] RQ_LOAD  = 5'b00000;
    localparam logic [4:0] RQ_STORE = 5'b00001;
    localparam logic [4:0] RQ_IFILL = 5'b10000;

    localparam logic [2:0] SIZE_1B  = 3'b001;
    localparam logic [2:0] SIZE_2B  = 3'b010;
    localparam logic [2:0] SIZE_4B  = 3'b011;
    localparam logic [2:0] SIZE_8B  = 3'b100;
    localparam logic [2:0] SIZE_16B = 3'b101;
    localparam logic [2:0] SIZE_32B = 3'b110;

    function automatic logic [2:0] stsize_to_code(input logic [1:0] stsize);
        logic [2:0] code;
        case (stsize)
            2'b00:   code = SIZE_1B;
            2'b01:   code = SIZE_2B;
            2'b10:   code = SIZE_4B;
            default: code = SIZE_8B;
        endcase
        return code;
    endfunction

    // Little-endian LSB-aligned store data -> big-endian chunk replicated over 64 bits.
    function automatic logic [63:0] swap_replicate(input logic [63:0] d, input logic [1:0] stsize);
        logic [63:0] r;
        case (stsize)
            2'b00:   r = {8{d[7:0]}};
            2'b01:   r = {4{d[7:0], d[15:8]}};
            2'b10:   r = {2{d[7:0], d[15:8], d[23:16], d[31:24]}};
            default: r = {d[7:0], d[15:8], d[23:16], d[31:24],
                          d[39:32], d[47:40], d[55:48], d[63:56]};
        endcase
        return r;
    endfunction

    function automatic src_e next_src(input src_e s);
        src_e n;
        case (s)
            SRC_IFILL: n = SRC_LOAD;
            SRC_LOAD:  n = SRC_STORE;
            default:   n = SRC_IFILL;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/l15_anycore_reqslot.sv
// One pending request slot: a valid flag plus the already-encoded address, data and size.
module l15_anycore_reqslot
    import l15_anycore_pkg::*;
#(
    parameter int PADDR_W = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [PADDR_W-1:0] addr_in,
    input  logic [63:0]        data_in,
    input  logic [2:0]         size_in,
    output logic               valid,
    output logic [PADDR_W-1:0] addr,
    output logic [63:0]        data,
    output logic [2:0]         size
);

    // Load wins over clear so a pulse landing in the ack cycle is kept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed while valid is set.
    always_ff @(posedge clk) begin
        if (load) begin
            addr <= addr_in;
            data <= data_in;
            size <= size_in;
        end
    end

endmodule

// File: rtl/l15_anycoredecoder_req.sv
// Anycore request decoder: captures I-fill/D-load/D-store pulses and issues one L1.5 request at a time.
// Define L15_ANYCORE_DECODER_RR_EN for round-robin arbitration; fixed IFILL > LOAD > STORE otherwise.
module l15_anycoredecoder_req
    import l15_anycore_pkg::*;
#(
    parameter int PADDR_W     = 40,
    parameter int TID_W       = 1,
    parameter int THREAD_ID   = 0,
    parameter int IC_LINE_LG2 = 5,
    parameter int DC_LINE_LG2 = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               anycore_ic2mem_reqvalid,
    input  logic [PADDR_W-1:0] anycore_ic2mem_reqaddr,
    input  logic               anycore_dc2mem_ldvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_ldaddr,
    input  logic               anycore_dc2mem_stvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_staddr,
    input  logic [63:0]        anycore_dc2mem_stdata,
    input  logic [1:0]         anycore_dc2mem_stsize,
    output logic               anycoredecoder_l15_val,
    output logic [4:0]         anycoredecoder_l15_rqtype,
    output logic               anycoredecoder_l15_nc,
    output logic [2:0]         anycoredecoder_l15_size,
    output logic [PADDR_W-1:0] anycoredecoder_l15_address,
    output logic [63:0]        anycoredecoder_l15_data,
    output logic [TID_W-1:0]   anycoredecoder_l15_threadid,
    input  logic               l15_anycoredecoder_ack,
    output logic               anycoredecoder_overflow
);

    state_e state, state_next;
    src_e   winner_q, pick;
    logic   grant;

    logic [NUM_SRC-1:0] pulse, pending, slot_valid, slot_load, slot_clear;
    logic [PADDR_W-1:0] in_addr   [NUM_SRC];
    logic [63:0]        in_data   [NUM_SRC];
    logic [2:0]         in_size   [NUM_SRC];
    logic [PADDR_W-1:0] slot_addr [NUM_SRC];
    logic [63:0]        slot_data [NUM_SRC];
    logic [2:0]         slot_size [NUM_SRC];

    assign pulse = {anycore_dc2mem_stvalid, anycore_dc2mem_ldvalid, anycore_ic2mem_reqvalid};

    always_comb begin
        in_addr[SRC_IFILL] = {anycore_ic2mem_reqaddr[PADDR_W-1:IC_LINE_LG2], {IC_LINE_LG2{1'b0}}};
        in_addr[SRC_LOAD]  = {anycore_dc2mem_ldaddr[PADDR_W-1:DC_LINE_LG2], {DC_LINE_LG2{1'b0}}};
        in_addr[SRC_STORE] = anycore_dc2mem_staddr;
        in_data[SRC_IFILL] = '0;
        in_data[SRC_LOAD]  = '0;
        in_data[SRC_STORE] = swap_replicate(anycore_dc2mem_stdata, anycore_dc2mem_stsize);
        in_size[SRC_IFILL] = SIZE_32B;
        in_size[SRC_LOAD]  = SIZE_16B;
        in_size[SRC_STORE] = stsize_to_code(anycore_dc2mem_stsize);
    end

    // An occupied slot accepts a new pulse only in the cycle its own ack frees it.
    assign slot_load = pulse & (~slot_valid | slot_clear);
    assign pending   = slot_valid | pulse;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        l15_anycore_reqslot #(.PADDR_W(PADDR_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (slot_load[g]),
            .clear   (slot_clear[g]),
            .addr_in (in_addr[g]),
            .data_in (in_data[g]),
            .size_in (in_size[g]),
            .valid   (slot_valid[g]),
            .addr    (slot_addr[g]),
            .data    (slot_data[g]),
            .size    (slot_size[g])
        );
    end

`ifdef L15_ANYCORE_DECODER_RR_EN
    src_e rr_ptr, cand;
    logic found;

    always_comb begin
        pick  = rr_ptr;
        cand  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && pending[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = next_src(cand);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= SRC_IFILL;
        end else if (grant) begin
            rr_ptr <= next_src(pick);
        end
    end
`else
    always_comb begin
        if (pending[SRC_IFILL])     pick = SRC_IFILL;
        else if (pending[SRC_LOAD]) pick = SRC_LOAD;
        else                        pick = SRC_STORE;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            winner_q <= SRC_IFILL;
        end else begin
            state <= state_next;
            if (grant) winner_q <= pick;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        slot_clear = '0;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    grant      = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (l15_anycoredecoder_ack) begin
                    slot_clear[winner_q] = 1'b1;
                    state_next           = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anycoredecoder_overflow <= 1'b0;
        end else if (|(pulse & slot_valid & ~slot_clear)) begin
            anycoredecoder_overflow <= 1'b1;
        end
    end

    // Request fields read zero whenever val is low.
    always_comb begin
        anycoredecoder_l15_val     = (state == ST_ISSUE);
        anycoredecoder_l15_rqtype  = '0;
        anycoredecoder_l15_nc      = 1'b0;
        anycoredecoder_l15_size    = '0;
        anycoredecoder_l15_address = '0;
        anycoredecoder_l15_data    = '0;
        if (anycoredecoder_l15_val) begin
            anycoredecoder_l15_address = slot_addr[winner_q];
            anycoredecoder_l15_nc      = slot_addr[winner_q][PADDR_W-1];
            anycoredecoder_l15_size    = slot_size[winner_q];
            anycoredecoder_l15_data    = slot_data[winner_q];
            case (winner_q)
                SRC_IFILL: anycoredecoder_l15_rqtype = RQ_IFILL;
                SRC_LOAD:  anycoredecoder_l15_rqtype = RQ_LOAD;
                default:   anycoredecoder_l15_rqtype = RQ_STORE;
            endcase
        end
    end

    assign anycoredecoder_l15_threadid = TID_W'(THREAD_ID);

endmodule

// File: tb/tb_l15_anycoredecoder_req.sv
// Directed bench for l15_anycoredecoder_req with a per-cycle reference model and literal spot checks.
module tb_l15_anycoredecoder_req;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_v, ld_v, st_v, ack;
    logic [39:0] ic_addr, ld_addr, st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_size;
    logic        val, nc, ovf;
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [39:0] address;
    logic [63:0] data;
    logic [0:0]  tid;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    l15_anycoredecoder_req dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .anycore_ic2mem_reqvalid     (ic_v),
        .anycore_ic2mem_reqaddr      (ic_addr),
        .anycore_dc2mem_ldvalid      (ld_v),
        .anycore_dc2mem_ldaddr       (ld_addr),
        .anycore_dc2mem_stvalid      (st_v),
        .anycore_dc2mem_staddr       (st_addr),
        .anycore_dc2mem_stdata       (st_data),
        .anycore_dc2mem_stsize       (st_size),
        .anycoredecoder_l15_val      (val),
        .anycoredecoder_l15_rqtype   (rqtype),
        .anycoredecoder_l15_nc       (nc),
        .anycoredecoder_l15_size     (size),
        .anycoredecoder_l15_address  (address),
        .anycoredecoder_l15_data     (data),
        .anycoredecoder_l15_threadid (tid),
        .l15_anycoredecoder_ack      (ack),
        .anycoredecoder_overflow     (ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: pending requests per source, one in flight ----------------
    bit          m_pend [3];
    logic [39:0] m_addr [3];
    logic [63:0] m_data [3];
    logic [2:0]  m_size [3];
    bit          m_busy, m_ovf, was_busy;
    int          m_cur, m_ptr;

    function automatic logic [63:0] be_rep(input logic [63:0] d, input logic [1:0] sz);
        int n;
        logic [63:0] r;
        n = 1 << sz;
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = d[8*(n - 1 - (k % n)) +: 8];
        return r;
    endfunction

    function automatic logic [4:0] exp_rq(input int s);
        return (s == 0) ? 5'b10000 : (s == 1) ? 5'b00000 : 5'b00001;
    endfunction

    task automatic cap(input int s, input logic [39:0] a, input logic [63:0] d, input logic [2:0] sz);
        if (m_pend[s]) m_ovf = 1'b1;
        else begin
            m_pend[s] = 1'b1;
            m_addr[s] = a;
            m_data[s] = d;
            m_size[s] = sz;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
            m_busy = 1'b0;
            m_ovf  = 1'b0;
            m_ptr  = 0;
            m_cur  = 0;
        end else begin
            was_busy = m_busy;
            if (was_busy && ack) begin
                m_pend[m_cur] = 1'b0;
                m_busy        = 1'b0;
            end
            if (ic_v) cap(0, ic_addr & ~40'h1F, 64'h0, 3'd6);
            if (ld_v) cap(1, ld_addr & ~40'hF, 64'h0, 3'd5);
            if (st_v) cap(2, st_addr, be_rep(st_data, st_size), 3'd1 + 3'(st_size));
            if (!was_busy) begin
                for (int i = 0; i < 3; i++) begin
`ifdef L15_ANYCORE_DECODER_RR_EN
                    int idx;
                    idx = (m_ptr + i) % 3;
`else
                    int idx;
                    idx = i;
`endif
                    if (!m_busy && m_pend[idx]) begin
                        m_busy = 1'b1;
                        m_cur  = idx;
                        m_ptr  = (idx + 1) % 3;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("val", val, m_busy);
            check("overflow", ovf, m_ovf);
            check("threadid", tid, 0);
            if (m_busy) begin
                check("rqtype", rqtype, exp_rq(m_cur));
                check("address", address, m_addr[m_cur]);
                check("nc", nc, m_addr[m_cur][39]);
                check("size", size, m_size[m_cur]);
                check("data", data, m_data[m_cur]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_val(input int lim);
        int n = 0;
        while (!val && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!val) check("wait_val_timeout", 0, 1);
    endtask

    task automatic burst();
        @(negedge clk);
        ic_v = 1; ic_addr = 40'h00_1000_0047;
        ld_v = 1; ld_addr = 40'h00_2000_0019;
        st_v = 1; st_addr = 40'h00_3000_0008; st_data = 64'h0102030405060708; st_size = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ic_v = 0; ld_v = 0; st_v = 0;
            check("burst_val", val, 1);
            check("burst_order", rqtype, (k == 0) ? 5'b10000 : (k == 1) ? 5'b00000 : 5'b00001);
            if (k == 0) check("burst_ifill_addr", address, 40'h00_1000_0040);
            if (k == 1) check("burst_load_addr", address, 40'h00_2000_0010);
            if (k == 2) check("burst_store_data", data, 64'h0807060504030201);
            ack = 1;
            @(negedge clk);
            ack = 0;
            check("burst_gap", val, 0);
        end
    endtask

    initial begin
        rst_n = 0; ack = 0;
        ic_v = 0; ld_v = 0; st_v = 0;
        ic_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; st_size = '0;
        @(posedge clk);
        cmp_en = 1;
        repeat (2) @(negedge clk);
        check("reset_val", val, 0);
        check("reset_ovf", ovf, 0);
        check("reset_addr", address, 0);
        check("reset_data", data, 0);
        check("reset_rqtype", rqtype, 0);
        rst_n = 1;

        // ack while idle is ignored
        @(negedge clk); ack = 1;
        @(negedge clk); ack = 0;
        check("idle_ack_val", val, 0);

        // single IFILL, ack in the third val cycle
        @(negedge clk); ic_v = 1; ic_addr = 40'h80_0000_1234;
        @(negedge clk); ic_v = 0;
        check("t1_val_n1", val, 1);
        check("t1_addr", address, 40'h80_0000_1220);
        check("t1_nc", nc, 1);
        check("t1_size", size, 3'b110);
        check("t1_rqtype", rqtype, 5'b10000);
        @(negedge clk); check("t1_val_n2", val, 1);
        @(negedge clk); check("t1_val_n3", val, 1); ack = 1;
        @(negedge clk); ack = 0; check("t1_val_drop", val, 0);

        // two identical bursts
        burst();
        burst();

        // store data swapping
        @(negedge clk); st_v = 1; st_addr = 40'h00_0000_1003; st_data = 64'h1234; st_size = 2'b01;
        @(negedge clk); st_v = 0;
        wait_val(4);
        check("t3_data_2b", data, 64'h3412341234123412);
        check("t3_size_2b", size, 3'b010);
        check("t3_addr", address, 40'h00_0000_1003);
        check("t3_nc", nc, 0);
        ack = 1;
        @(negedge clk); ack = 0;

        // LOAD pulse in the ack cycle is captured without overflow
        @(negedge clk); ld_v = 1; ld_addr = 40'h00_0000_0123;
        @(negedge clk); ld_addr = 40'h00_0000_0456; ack = 1;
        check("t4b_first_addr", address, 40'h00_0000_0120);
        @(negedge clk); ld_v = 0; ack = 0;
        check("t4b_gap", val, 0);
        check("t4b_no_ovf", ovf, 0);
        @(negedge clk);
        check("t4b_second_val", val, 1);
        check("t4b_second_addr", address, 40'h00_0000_0450);
        ack = 1;
        @(negedge clk); ack = 0;

        // LOAD pulse on an occupied slot is dropped and flags overflow
        @(negedge clk); ld_v = 1; ld_addr = 40'h00_0000_0780;
        @(negedge clk); ld_addr = 40'h00_0000_0990;
        @(negedge clk); ld_v = 0;
        check("t4a_ovf", ovf, 1);
        check("t4a_addr_kept", address, 40'h00_0000_0780);
        ack = 1;
        @(negedge clk); ack = 0;
        check("t4a_ovf_sticky", ovf, 1);
        repeat (2) @(negedge clk);
        check("t4a_dropped", val, 0);

        // reset during ISSUE with no ack
        @(negedge clk); ic_v = 1; ic_addr = 40'h00_0000_0040;
        @(negedge clk); ic_v = 0;
        check("t5_issue", val, 1);
        rst_n = 0;
        @(negedge clk);
        check("t5_val_reset", val, 0);
        check("t5_ovf_reset", ovf, 0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_quiet", val, 0);
        end
        @(negedge clk); st_v = 1; st_addr = 40'h00_0000_0077; st_data = 64'h00AB; st_size = 2'b00;
        @(negedge clk); st_v = 0;
        wait_val(4);
        check("t5_new_data", data, 64'hABABABABABABABAB);
        check("t5_new_size", size, 3'b001);
        ack = 1;
        @(negedge clk); ack = 0;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
